// File: rtl/seq_mem_d1_dp.sv
`default_nettype none
// ============================================================================
// Module   : seq_mem_d1_dp
// Brief    : Simple dual-port sequential memory with byte enables, pipelined
//            reads, selectable collision policy and sticky out-of-bounds flag.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mem_d1_dp #(
   parameter int WIDTH        = 32,
   parameter int SIZE         = 144,
   parameter int IDX_SIZE     = 8,
   parameter int BYTE_W       = 8,
   parameter int READ_LATENCY = 1,
   parameter int WRITE_FIRST  = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [IDX_SIZE-1:0]       raddr,
   input  logic                      read_en,
   output logic [WIDTH-1:0]          out,
   output logic                      read_done,
   input  logic [IDX_SIZE-1:0]       waddr,
   input  logic [WIDTH-1:0]          in,
   input  logic [WIDTH/BYTE_W-1:0]   wbe,
   input  logic                      write_en,
   output logic                      write_done,
   output logic                      err
);

   localparam int NB = WIDTH / BYTE_W;
   localparam logic [IDX_SIZE:0] c_size = SIZE[IDX_SIZE:0];

   logic [WIDTH-1:0] mem [0:SIZE-1];

   logic             raddr_ok;
   logic             waddr_ok;
   logic             collide;
   logic [WIDTH-1:0] wr_word;
   logic [WIDTH-1:0] rd_word;
   logic             tail_vld;
   logic [WIDTH-1:0] tail_data;

   logic [WIDTH-1:0] out_q, out_d;
   logic             read_done_q, read_done_d;
   logic             write_done_q, write_done_d;
   logic             err_q, err_d;

   assign raddr_ok = ({1'b0, raddr} < c_size);
   assign waddr_ok = ({1'b0, waddr} < c_size);
   assign collide  = read_en && write_en && waddr_ok && (raddr == waddr);

   // Merged word: new data on enabled lanes, current contents elsewhere.
   always_comb begin
      wr_word = mem[waddr];
      for (int i = 0; i < NB; i++) begin
         if (wbe[i]) begin
            wr_word[i*BYTE_W +: BYTE_W] = in[i*BYTE_W +: BYTE_W];
         end
      end
   end

   always_comb begin
      rd_word = '0;
      if (raddr_ok) begin
         if ((WRITE_FIRST != 0) && collide) begin
            rd_word = wr_word;
         end else begin
            rd_word = mem[raddr];
         end
      end
   end

   // The array has no reset: a write in the reset cycle still lands.
   always_ff @(posedge clk) begin
      if (write_en && waddr_ok) begin
         mem[waddr] <= wr_word;
      end
   end

   // The output register is the last pipeline stage; earlier stages live here.
   if (READ_LATENCY == 1) begin : g_lat1
      assign tail_vld  = read_en;
      assign tail_data = rd_word;
   end else begin : g_latn
      localparam int NS = READ_LATENCY - 1;

      logic [NS-1:0]    vld_q, vld_d;
      logic [WIDTH-1:0] data_q [NS];
      logic [WIDTH-1:0] data_d [NS];

      always_comb begin
         vld_d[0]  = read_en;
         data_d[0] = rd_word;
         for (int k = 1; k < NS; k++) begin
            vld_d[k]  = vld_q[k-1];
            data_d[k] = data_q[k-1];
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            vld_q <= '0;
         end else begin
            vld_q <= vld_d;
         end
         data_q <= data_d;
      end

      assign tail_vld  = vld_q[NS-1];
      assign tail_data = data_q[NS-1];
   end

   always_comb begin
      out_d        = tail_vld ? tail_data : out_q;
      read_done_d  = tail_vld;
      write_done_d = write_en;
      err_d        = err_q | (read_en & ~raddr_ok) | (write_en & ~waddr_ok);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q        <= '0;
         read_done_q  <= 1'b0;
         write_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         out_q        <= out_d;
         read_done_q  <= read_done_d;
         write_done_q <= write_done_d;
         err_q        <= err_d;
      end
   end

   assign out        = out_q;
   assign read_done  = read_done_q;
   assign write_done = write_done_q;
   assign err        = err_q;

endmodule
`default_nettype wire
